// File: rtl/sme_pkg.sv
// Shared types and constants for the sme_param string-matching engine.
//   state_e    : controller states
//   cmp_mode_e : how the single-element matcher interprets one comparison
//   CARET, DOLLAR, DOT, STAR, SPACE : 8-bit meta/separator character codes
package sme_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_STR,
    LD_PAT,
    SEARCH,
    REPORT
  } state_e;

  typedef enum logic [1:0] {
    CMP_LIT,   // literal character compare
    CMP_ANY,   // '.' wildcard: any in-range character
    CMP_BOUND  // word boundary: string edge or a space
  } cmp_mode_e;

  localparam logic [7:0] CARET  = 8'h5E;
  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] STAR   = 8'h2A;
  localparam logic [7:0] SPACE  = 8'h20;

endpackage

// File: rtl/sme_char_cmp.sv
// Combinational single-element matcher for sme_param.
// Optional build macro: SME_CASE_FOLD_EN (fold ASCII 'A'-'Z' onto 'a'-'z'
// in literal compares; only the low 8 bits are folded, CW >= 8).
// Ports:
//   str_char : string character under test
//   pat_char : pattern character (used by CMP_LIT only)
//   mode     : literal / any-character / word-boundary test
//   at_edge  : the probed string position lies outside the stored string
//   hit      : element matches
module sme_char_cmp
  import sme_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] str_char,
  input  logic [CW-1:0] pat_char,
  input  cmp_mode_e     mode,
  input  logic          at_edge,
  output logic          hit
);

  logic [CW-1:0] str_f;
  logic [CW-1:0] pat_f;

  always_comb begin
    str_f = str_char;
    pat_f = pat_char;
`ifdef SME_CASE_FOLD_EN
    // Upper-case ASCII differs from lower-case only in bit 5.
    if (str_f[7:0] >= 8'h41 && str_f[7:0] <= 8'h5A) str_f[5] = 1'b1;
    if (pat_f[7:0] >= 8'h41 && pat_f[7:0] <= 8'h5A) pat_f[5] = 1'b1;
`endif
    case (mode)
      CMP_ANY:   hit = !at_edge;
      // Outside the string counts as a boundary; inside, only a space does.
      CMP_BOUND: hit = at_edge || (str_char == CW'(SPACE));
      default:   hit = !at_edge && (str_f == pat_f);
    endcase
  end

endmodule

// File: rtl/sme_param.sv
// Parametrised serial-load string-matching engine.
// Optional build macro: SME_CASE_FOLD_EN (case-insensitive literal compares,
// implemented inside sme_char_cmp).
// Ports:
//   clk, reset_n          : clock (rising edge), async active-low reset
//   chardata              : input character
//   isstring / ispattern  : chardata is the next string / pattern character
//   valid                 : one-cycle pulse, search finished
//   match                 : pattern found (qualified by valid)
//   match_index           : leftmost match start, 0-based
//   match_len             : string characters consumed by the match
//   busy                  : high while searching
module sme_param
  import sme_pkg::*;
#(
  parameter int CW      = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IW      = $clog2(STR_MAX)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] chardata,
  input  logic          isstring,
  input  logic          ispattern,
  output logic          valid,
  output logic          match,
  output logic [IW-1:0] match_index,
  output logic [IW:0]   match_len,
  output logic          busy
);

  localparam int PW = $clog2(PAT_MAX);
  typedef logic [IW:0] slen_t;
  typedef logic [PW:0] plen_t;

  logic [CW-1:0] str_mem [STR_MAX];
  logic [CW-1:0] pat_mem [PAT_MAX];

  state_e        state_q, state_d;
  slen_t         str_len_q, str_len_d;
  plen_t         pat_len_q, pat_len_d;
  slen_t         s_q, s_d;          // candidate start
  slen_t         i_q, i_d;          // string read pointer
  slen_t         t_q, t_d;          // suffix anchor after '*'
  plen_t         k_q, k_d;          // pattern element pointer
  logic          suffix_q, suffix_d;
  logic          valid_q, valid_d;
  logic          match_q, match_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] match_index_q, match_index_d;
  slen_t         match_len_q, match_len_d;

  logic          str_we, pat_we;
  logic [IW-1:0] str_waddr;
  logic [PW-1:0] pat_waddr;

  // Pattern decode: anchors, star position and the current segment end.
  logic          has_caret, has_dollar, has_star;
  logic [PW-1:0] pat_last;
  plen_t         body_end, star_pos, seg_end;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    pat_last   = PW'(pat_len_q - plen_t'(1));
    has_caret  = (pat_len_q != '0) && (pat_mem[0] == CW'(CARET));
    has_dollar = (pat_len_q != '0) && (pat_mem[pat_last] == CW'(DOLLAR));
    body_end   = pat_len_q - plen_t'(has_dollar);
    has_star   = 1'b0;
    star_pos   = body_end;
    for (int j = 0; j < PAT_MAX; j++) begin
      if (!has_star && plen_t'(j) >= plen_t'(has_caret) && plen_t'(j) < body_end &&
          pat_mem[j] == CW'(STAR)) begin
        has_star = 1'b1;
        star_pos = plen_t'(j);
      end
    end
    seg_end = (has_star && !suffix_q) ? star_pos : body_end;
  end

  // Per-cycle element selection for the single comparator.
  logic          caret_step, end_step, star_step;
  logic [IW-1:0] rd_addr;
  logic [CW-1:0] cmp_str, cmp_pat;
  cmp_mode_e     cmp_mode;
  logic          cmp_edge, cmp_hit;

  always_comb begin
    caret_step = !suffix_q && has_caret && (k_q == '0);
    end_step   = !caret_step && (k_q == seg_end);
    star_step  = end_step && has_star && !suffix_q;
    // The caret test looks at the character just before the candidate start.
    rd_addr    = caret_step ? IW'(s_q - slen_t'(1)) : IW'(i_q);
    cmp_str    = str_mem[rd_addr];
    cmp_pat    = pat_mem[k_q[PW-1:0]];
    cmp_mode   = CMP_LIT;
    cmp_edge   = (i_q >= str_len_q);
    if (caret_step) begin
      cmp_mode = CMP_BOUND;
      cmp_edge = (s_q == '0);
    end else if (end_step) begin
      cmp_mode = CMP_BOUND;            // '$' test; ignored when there is no '$'
    end else if (cmp_pat == CW'(DOT)) begin
      cmp_mode = CMP_ANY;
    end
  end

  sme_char_cmp #(.CW(CW)) u_cmp (
    .str_char (cmp_str),
    .pat_char (cmp_pat),
    .mode     (cmp_mode),
    .at_edge  (cmp_edge),
    .hit      (cmp_hit)
  );

  always_comb begin
    state_d       = state_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    s_d           = s_q;
    i_d           = i_q;
    t_d           = t_q;
    k_d           = k_q;
    suffix_d      = suffix_q;
    match_d       = match_q;
    match_index_d = match_index_q;
    match_len_d   = match_len_q;
    str_we        = 1'b0;
    pat_we        = 1'b0;
    str_waddr     = IW'(str_len_q);
    pat_waddr     = PW'(pat_len_q);

    if (isstring) begin
      state_d = LD_STR;
      if (state_q != LD_STR) begin
        str_we    = 1'b1;
        str_waddr = '0;
        str_len_d = slen_t'(1);
      end else if (str_len_q < slen_t'(STR_MAX)) begin
        str_we    = 1'b1;
        str_len_d = str_len_q + slen_t'(1);
      end
    end else if (ispattern) begin
      state_d = LD_PAT;
      if (state_q != LD_PAT) begin
        pat_we    = 1'b1;
        pat_waddr = '0;
        pat_len_d = plen_t'(1);
      end else if (pat_len_q < plen_t'(PAT_MAX)) begin
        pat_we    = 1'b1;
        pat_len_d = pat_len_q + plen_t'(1);
      end
    end else begin
      case (state_q)
        LD_STR: state_d = IDLE;
        LD_PAT: begin
          state_d  = SEARCH;
          s_d      = '0;
          i_d      = '0;
          t_d      = '0;
          k_d      = '0;
          suffix_d = 1'b0;
        end
        SEARCH: begin
          if (star_step) begin
            suffix_d = 1'b1;
            t_d      = i_q;
            k_d      = star_pos + plen_t'(1);
          end else if (cmp_hit && !end_step) begin
            if (caret_step) begin
              k_d = plen_t'(1);
            end else begin
              i_d = i_q + slen_t'(1);
              k_d = k_q + plen_t'(1);
            end
          end else if (end_step && (cmp_hit || !has_dollar)) begin
            state_d       = REPORT;
            match_d       = 1'b1;
            match_index_d = IW'(s_q);
            match_len_d   = i_q - s_q;
          end else if (suffix_q) begin
            // Suffix tries do not depend on the start, so once every t has
            // failed no later start can succeed: report no match right away.
            if (t_q >= str_len_q) begin
              state_d       = REPORT;
              match_d       = 1'b0;
              match_index_d = '0;
              match_len_d   = '0;
            end else begin
              t_d = t_q + slen_t'(1);
              i_d = t_q + slen_t'(1);
              k_d = star_pos + plen_t'(1);
            end
          end else if (s_q + slen_t'(1) >= str_len_q) begin
            state_d       = REPORT;
            match_d       = 1'b0;
            match_index_d = '0;
            match_len_d   = '0;
          end else begin
            s_d = s_q + slen_t'(1);
            i_d = s_q + slen_t'(1);
            k_d = '0;
          end
        end
        REPORT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    valid_d = (state_d == REPORT);
    busy_d  = (state_d == SEARCH);
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values; combinational blocks above use blocking ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      s_q           <= '0;
      i_q           <= '0;
      t_q           <= '0;
      k_q           <= '0;
      suffix_q      <= 1'b0;
      valid_q       <= 1'b0;
      match_q       <= 1'b0;
      busy_q        <= 1'b0;
      match_index_q <= '0;
      match_len_q   <= '0;
    end else begin
      state_q       <= state_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      s_q           <= s_d;
      i_q           <= i_d;
      t_q           <= t_d;
      k_q           <= k_d;
      suffix_q      <= suffix_d;
      valid_q       <= valid_d;
      match_q       <= match_d;
      busy_q        <= busy_d;
      match_index_q <= match_index_d;
      match_len_q   <= match_len_d;
    end
  end

  // NOTE: buffer contents are never read beyond the stored lengths, so the
  // memories carry no reset and can map onto plain register files.
  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_waddr] <= chardata;
    if (pat_we) pat_mem[pat_waddr] <= chardata;
  end

  assign valid       = valid_q;
  assign match       = match_q;
  assign match_index = match_index_q;
  assign match_len   = match_len_q;
  assign busy        = busy_q;

endmodule
